// File: rtl/p2s_miso_tx.sv
// p2s_miso_tx: SPI mode-0 slave transmit path, WL-bit word shifted out MSB first on MISO
// Ports:
//   clk, iRST           system clock, synchronous active-high reset
//   sck_in, cs_n_in     raw asynchronous SPI pins, oversampled in clk
//   tx_data, tx_load    parallel word and write strobe (taken only while tx_ready)
//   tx_ready            holding buffer empty
//   miso, miso_oe       serial data out and its tristate enable
//   tx_done, tx_abort   frame complete / CS_n raised mid-frame (one-cycle pulses)
//   underrun            frame started with an empty buffer (one-cycle pulse)
module p2s_miso_tx #(
  parameter int WL = 96,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          iRST,
  input  logic          sck_in,
  input  logic          cs_n_in,
  input  logic [WL-1:0] tx_data,
  input  logic          tx_load,
  output logic          tx_ready,
  output logic          miso,
  output logic          miso_oe,
  output logic          tx_done,
  output logic          tx_abort,
  output logic          underrun
);
  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;
  state_t state, state_d;
  logic [2:0] sck_s, cs_s;
  logic [WL-1:0] buffer, shift_reg;
  logic buf_valid, done_d, abort_d, under_d;
  logic [CW-1:0] bit_cnt;
  logic sck_rise, sck_fall, cs_fall, cs_rise;
  // bit 1 is the synchronized pin, bit 2 its one-cycle history
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign cs_fall  = ~cs_s[1] & cs_s[2];
  assign cs_rise  = cs_s[1] & ~cs_s[2];
  assign tx_ready = ~buf_valid;
  assign miso_oe  = ~cs_s[1];
  assign miso     = (state == SHIFT) ? shift_reg[WL-1] : 1'b0;
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    abort_d = 1'b0;
    under_d = 1'b0;
    if (state == IDLE && cs_fall) begin
      state_d = SHIFT;
      under_d = ~buf_valid;
    end else if (state == SHIFT && cs_rise) begin
      state_d = IDLE;
      abort_d = 1'b1;
    end else if (state == SHIFT && sck_rise && bit_cnt == CW'(WL-1)) begin
      state_d = DRAIN;
      done_d  = 1'b1;
    end else if (state == DRAIN && cs_rise) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (iRST) begin
      state     <= IDLE;
      sck_s     <= 3'b000;
      cs_s      <= 3'b111;
      buffer    <= '0;
      buf_valid <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tx_done   <= 1'b0;
      tx_abort  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      sck_s    <= {sck_s[1:0], sck_in};
      cs_s     <= {cs_s[1:0], cs_n_in};
      state    <= state_d;
      tx_done  <= done_d;
      tx_abort <= abort_d;
      underrun <= under_d;
      if (tx_load && !buf_valid) begin
        buffer    <= tx_data;
        buf_valid <= 1'b1;
      end
      // a load in the cs_fall cycle only happens with the buffer empty, so it is kept for the next frame
      if (state == IDLE && cs_fall) begin
        bit_cnt   <= '0;
        shift_reg <= buf_valid ? buffer : '0;
        if (buf_valid) buf_valid <= 1'b0;
      end
      if (state == SHIFT && sck_rise) bit_cnt <= bit_cnt + 1'b1;
      if (state == SHIFT && sck_fall) shift_reg <= {shift_reg[WL-2:0], 1'b0};
    end
  end
endmodule

// File: tb/tb_p2s_miso_tx.sv
// tb_p2s_miso_tx: scoreboard bench driving directed SPI frames into p2s_miso_tx
module tb_p2s_miso_tx;
  localparam int WL = 96;
  localparam int CW = 7;
  localparam int HP = 8;
  logic clk = 1'b0, iRST = 1'b1, sck_in = 1'b0, cs_n_in = 1'b1, tx_load = 1'b0;
  logic [WL-1:0] tx_data = '0;
  logic tx_ready, miso, miso_oe, tx_done, tx_abort, underrun;
  logic [WL-1:0] rx_word = '0;
  int checks = 0, errors = 0;
  int ev_q[$];
  logic [WL-1:0] word_q[$];
  localparam logic [WL-1:0] WA = 96'hA5A5_0000_FFFF_1234_5678_9ABC;
  localparam logic [WL-1:0] W1 = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
  localparam logic [WL-1:0] W2 = 96'h1111_2222_3333_4444_5555_6666;
  localparam logic [WL-1:0] WX = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [WL-1:0] W5 = 96'h8000_0000_0000_0000_0000_0001;
  localparam logic [WL-1:0] W6 = 96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
  localparam logic [WL-1:0] W7 = 96'h5555_AAAA_5555_AAAA_5555_AAAA;
  p2s_miso_tx #(.WL(WL), .CW(CW)) dut (
    .clk(clk), .iRST(iRST), .sck_in(sck_in), .cs_n_in(cs_n_in),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .miso(miso), .miso_oe(miso_oe), .tx_done(tx_done),
    .tx_abort(tx_abort), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [WL-1:0] act, input logic [WL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic expect_ev(input int code, input logic [WL-1:0] w);
    ev_q.push_back(code);
    if (code == 0) word_q.push_back(w);
  endtask
  // codes: 0 tx_done, 1 tx_abort, 2 underrun
  always @(negedge clk) begin
    if (!iRST && (tx_done || tx_abort || underrun)) begin
      int code;
      code = tx_done ? 0 : tx_abort ? 1 : 2;
      if (ev_q.size() == 0) chk("unexpected_pulse", WL'(code), WL'(99));
      else begin
        chk("event_kind", WL'(code), WL'(ev_q.pop_front()));
        if (code == 0) chk("rx_word", rx_word, word_q.pop_front());
      end
    end
  end
  task automatic load(input logic [WL-1:0] w);
    tx_data = w;
    tx_load = 1'b1;
    @(posedge clk); #1;
    tx_load = 1'b0;
  endtask
  task automatic frame(input int nbits, input bit ld, input logic [WL-1:0] ldw, input int rst_at, input bit chk_ready);
    cs_n_in = 1'b0;
    rx_word = '0;
    repeat (2) @(posedge clk);
    #1;
    if (ld) begin
      tx_data = ldw;
      tx_load = 1'b1;
    end
    @(posedge clk); #1;
    tx_load = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    if (chk_ready) begin
      chk("ready_after_cs_fall", WL'(tx_ready), WL'(1));
      chk("miso_oe_in_frame", WL'(miso_oe), WL'(1));
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        iRST = 1'b1;
        cs_n_in = 1'b1;
        @(posedge clk); #1;
        chk("rst_miso", WL'(miso), WL'(0));
        chk("rst_ready", WL'(tx_ready), WL'(1));
        chk("rst_pulses", WL'({tx_done, tx_abort, underrun}), WL'(0));
        iRST = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        return;
      end
      rx_word = {rx_word[WL-2:0], miso};
      sck_in = 1'b1;
      repeat (HP) @(posedge clk);
      #1 sck_in = 1'b0;
      repeat (HP) @(posedge clk);
      #1;
    end
    cs_n_in = 1'b1;
    repeat (HP) @(posedge clk);
    #1;
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: time %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", WL'(tx_ready), WL'(1));
    chk("reset_miso", WL'(miso), WL'(0));
    chk("reset_oe", WL'(miso_oe), WL'(0));
    chk("reset_pulses", WL'({tx_done, tx_abort, underrun}), WL'(0));
    iRST = 1'b0;
    @(posedge clk); #1;
    load(WA);
    chk("ready_after_load", WL'(tx_ready), WL'(0));
    expect_ev(0, WA);
    frame(WL, 0, '0, -1, 1);
    expect_ev(2, '0);
    expect_ev(0, '0);
    frame(WL, 0, '0, -1, 0);
    load(W1);
    load(W2);
    chk("ready_still_full", WL'(tx_ready), WL'(0));
    expect_ev(0, W1);
    frame(WL, 0, '0, -1, 0);
    load(WX);
    expect_ev(1, '0);
    frame(40, 0, '0, -1, 0);
    load(96'h1);
    expect_ev(0, 96'h1);
    frame(WL, 0, '0, -1, 0);
    expect_ev(2, '0);
    expect_ev(0, '0);
    frame(WL, 1, W5, -1, 0);
    chk("ready_after_same_cycle_load", WL'(tx_ready), WL'(0));
    expect_ev(0, W5);
    frame(WL, 0, '0, -1, 0);
    load(W6);
    frame(WL, 0, '0, 50, 0);
    load(W7);
    expect_ev(0, W7);
    frame(WL, 0, '0, -1, 0);
    repeat (10) @(posedge clk);
    chk("events_left", WL'(ev_q.size()), WL'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
